// File: rtl/quad_sample_collector.sv
// -----------------------------------------------------------------------------
// quad_sample_collector
//
// Purpose:
//   Upstream feeder for minimum_index. Takes a serial stream of WIDTH-bit
//   samples over a valid/ready handshake and packs four consecutive samples
//   into the registered quad a,b,c,d. A completed quad is presented with
//   out_valid and held stable until out_ready. A flush closes a partial quad
//   by padding the empty slots with all-ones, so the stream tail is not lost.
//
// Handshake semantics (both sides):
//   A transfer happens in a cycle where valid and ready are both high at the
//   rising clock edge. On the input side, in_ready depends only on state and
//   rst. On the output side, out_valid is registered and the quad stays
//   stable until the cycle in which out_ready is sampled high.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     in_data carries a sample this cycle
//   in_data      sample value [WIDTH-1:0]
//   in_ready     collector can accept a sample this cycle
//   flush        close the current partial quad, padding empty slots
//   a,b,c,d      quad slots 0..3 (to minimum_index)
//   out_valid    a,b,c,d hold a complete quad
//   out_ready    consumer has taken the quad this cycle
//   group_count  number of quads handed off since reset (wraps)
//   drop_err     sticky: a sample was offered while in_ready was low
//   dbg_state    current FSM state (0 = FILL, 1 = HOLD)
// -----------------------------------------------------------------------------
module quad_sample_collector #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] group_count,
    output logic             drop_err,
    output logic             dbg_state
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] PAD = {WIDTH{1'b1}};

    state_t           r_state;
    logic [1:0]       r_fill_ptr;
    logic [WIDTH-1:0] r_slot [4];
    logic [CNT_W-1:0] r_group_count;
    logic             r_drop_err;

    state_t           w_state_next;
    logic [1:0]       w_fill_ptr_next;
    logic [WIDTH-1:0] w_slot_next [4];
    logic [CNT_W-1:0] w_group_count_next;
    logic             w_accept;
    logic             w_flush_go;
    logic [2:0]       w_pad_from;

    assign in_ready = (r_state == FILL) && !rst;
    assign w_accept = in_valid && in_ready;

    // First slot to pad: the slot after an accepted sample, otherwise the
    // current fill pointer. Value 4 means nothing is padded.
    assign w_pad_from = {1'b0, r_fill_ptr} + {2'b00, w_accept};

    always_comb begin
        w_state_next       = r_state;
        w_fill_ptr_next    = r_fill_ptr;
        w_slot_next        = r_slot;
        w_group_count_next = r_group_count;
        w_flush_go         = 1'b0;

        case (r_state)
            FILL: begin
                // A flush on an empty quad with no sample has nothing to close.
                w_flush_go = flush && (w_accept || (r_fill_ptr != 2'd0));
                for (int i = 0; i < 4; i++) begin
                    if (w_accept && (r_fill_ptr == 2'(i))) begin
                        w_slot_next[i] = in_data;
                    end else if (w_flush_go && (3'(i) >= w_pad_from)) begin
                        w_slot_next[i] = PAD;
                    end
                end
                if (w_accept) begin
                    w_fill_ptr_next = r_fill_ptr + 2'd1;
                end
                if (w_flush_go || (w_accept && (r_fill_ptr == 2'd3))) begin
                    w_state_next    = HOLD;
                    w_fill_ptr_next = 2'd0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_next       = FILL;
                    w_fill_ptr_next    = 2'd0;
                    w_group_count_next = r_group_count + 1'b1;
                end
            end
            default: begin
                w_state_next = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FILL;
            r_fill_ptr    <= 2'd0;
            r_group_count <= '0;
            r_drop_err    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_state       <= w_state_next;
            r_fill_ptr    <= w_fill_ptr_next;
            r_group_count <= w_group_count_next;
            r_slot        <= w_slot_next;
            if (in_valid && !in_ready) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    assign a           = r_slot[0];
    assign b           = r_slot[1];
    assign c           = r_slot[2];
    assign d           = r_slot[3];
    assign out_valid   = (r_state == HOLD);
    assign group_count = r_group_count;
    assign drop_err    = r_drop_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_quad_sample_collector.sv
// -----------------------------------------------------------------------------
// tb_quad_sample_collector
//
// Directed vector table for the single-cycle behaviour, followed by
// hand-written sequences for the held-quad/drop case and the 256-quad
// group_count wrap run.
// -----------------------------------------------------------------------------
module tb_quad_sample_collector;

    localparam int WIDTH = 3;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             flush;
    logic [WIDTH-1:0] a, b, c, d;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] group_count;
    logic             drop_err;
    logic             dbg_state;

    int n_checks;
    int n_errors;

    quad_sample_collector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .flush       (flush),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .group_count (group_count),
        .drop_err    (drop_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        iv;
        logic [2:0]  id;
        logic        fl;
        logic        ordy;
        logic        exp_rdy;   // in_ready during the cycle (before the edge)
        logic        exp_ov;    // after the edge
        logic [11:0] exp_abcd;  // {a,b,c,d} after the edge
        logic [7:0]  exp_cnt;
        logic        exp_drop;
        logic        chk_abcd;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [11:0] q4(input int va, input int vb, input int vc, input int vd);
        return {3'(va), 3'(vb), 3'(vc), 3'(vd)};
    endfunction

    function automatic void add(input logic r, input logic iv, input int id, input logic fl,
                                input logic ordy, input logic rdy, input logic ov,
                                input logic [11:0] abcd, input int cnt, input logic drop);
        vec_t v;
        v.rst = r; v.iv = iv; v.id = 3'(id); v.fl = fl; v.ordy = ordy;
        v.exp_rdy = rdy; v.exp_ov = ov; v.exp_abcd = abcd; v.exp_cnt = 8'(cnt);
        v.exp_drop = drop; v.chk_abcd = 1'b1;
        vecs.push_back(v);
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [2:0] id,
                         input logic fl, input logic ordy);
        @(negedge clk);
        rst = r; in_valid = iv; in_data = id; flush = fl; out_ready = ordy;
        #1;
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quad(input string name, input logic [11:0] exp);
        check(name, {20'd0, a, b, c, d}, {20'd0, exp});
    endtask

    // ---------------- scoreboard for the wrap run ----------------
    logic [11:0] exp_q[$];

    initial begin
        logic [11:0] held;
        logic [11:0] got;
        logic [11:0] cur;
        int          beat;
        int          seq;
        int          quads_seen;
        int          exp_cnt;
        logic        prev_ov;
        int          budget;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

        // reset
        add(1, 1, 5, 0, 0,  0, 0, q4(0,0,0,0), 0, 0);
        // basic quad 7,3,2,1 then handoff
        add(0, 1, 7, 0, 0,  1, 0, q4(7,0,0,0), 0, 0);
        add(0, 1, 3, 0, 0,  1, 0, q4(7,3,0,0), 0, 0);
        add(0, 1, 2, 0, 0,  1, 0, q4(7,3,2,0), 0, 0);
        add(0, 1, 1, 0, 0,  1, 1, q4(7,3,2,1), 0, 0);
        add(0, 0, 0, 0, 0,  0, 1, q4(7,3,2,1), 0, 0);
        add(0, 0, 0, 0, 1,  0, 0, q4(7,3,2,1), 1, 0);
        // 4,1 then flush alone
        add(0, 1, 4, 0, 0,  1, 0, q4(4,3,2,1), 1, 0);
        add(0, 1, 1, 0, 0,  1, 0, q4(4,1,2,1), 1, 0);
        add(0, 0, 0, 1, 0,  1, 1, q4(4,1,7,7), 1, 0);
        add(0, 0, 0, 0, 1,  0, 0, q4(4,1,7,7), 2, 0);
        // flush on empty quad is ignored
        add(0, 0, 0, 1, 0,  1, 0, q4(4,1,7,7), 2, 0);
        // 0,0 then 6 with flush
        add(0, 1, 0, 0, 0,  1, 0, q4(0,1,7,7), 2, 0);
        add(0, 1, 0, 0, 0,  1, 0, q4(0,0,7,7), 2, 0);
        add(0, 1, 6, 1, 0,  1, 1, q4(0,0,6,7), 2, 0);
        add(0, 0, 0, 0, 1,  0, 0, q4(0,0,6,7), 3, 0);
        // 3,3,3 then 2 with flush: no padding
        add(0, 1, 3, 0, 0,  1, 0, q4(3,0,6,7), 3, 0);
        add(0, 1, 3, 0, 0,  1, 0, q4(3,3,6,7), 3, 0);
        add(0, 1, 3, 0, 0,  1, 0, q4(3,3,3,7), 3, 0);
        add(0, 1, 2, 1, 0,  1, 1, q4(3,3,3,2), 3, 0);
        // flush in HOLD is ignored
        add(0, 0, 0, 1, 0,  0, 1, q4(3,3,3,2), 3, 0);
        add(0, 0, 0, 0, 1,  0, 0, q4(3,3,3,2), 4, 0);
        // bubbles: 2,_,3,_,_,6,1
        add(0, 1, 2, 0, 0,  1, 0, q4(2,3,3,2), 4, 0);
        add(0, 0, 5, 0, 0,  1, 0, q4(2,3,3,2), 4, 0);
        add(0, 1, 3, 0, 0,  1, 0, q4(2,3,3,2), 4, 0);
        add(0, 0, 4, 0, 0,  1, 0, q4(2,3,3,2), 4, 0);
        add(0, 0, 0, 0, 0,  1, 0, q4(2,3,3,2), 4, 0);
        add(0, 1, 6, 0, 0,  1, 0, q4(2,3,6,2), 4, 0);
        add(0, 1, 1, 0, 0,  1, 1, q4(2,3,6,1), 4, 0);
        add(0, 0, 0, 0, 1,  0, 0, q4(2,3,6,1), 5, 0);
        // out_ready ignored in FILL
        add(0, 0, 0, 0, 1,  1, 0, q4(2,3,6,1), 5, 0);
        // mid-quad reset
        add(0, 1, 4, 0, 0,  1, 0, q4(4,3,6,1), 5, 0);
        add(0, 1, 6, 0, 0,  1, 0, q4(4,6,6,1), 5, 0);
        add(1, 1, 2, 1, 0,  0, 0, q4(0,0,0,0), 0, 0);
        add(0, 1, 5, 0, 0,  1, 0, q4(5,0,0,0), 0, 0);
        add(0, 1, 1, 0, 0,  1, 0, q4(5,1,0,0), 0, 0);
        add(0, 1, 7, 0, 0,  1, 0, q4(5,1,7,0), 0, 0);
        add(0, 1, 4, 0, 0,  1, 1, q4(5,1,7,4), 0, 0);
        add(0, 0, 0, 0, 0,  0, 1, q4(5,1,7,4), 0, 0);
        add(0, 0, 0, 0, 1,  0, 0, q4(5,1,7,4), 1, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].id, vecs[i].fl, vecs[i].ordy);
            check($sformatf("v%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_rdy});
            step_edge();
            check($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].exp_ov});
            check($sformatf("v%0d group_count", i), {24'd0, group_count}, {24'd0, vecs[i].exp_cnt});
            check($sformatf("v%0d drop_err", i), {31'd0, drop_err}, {31'd0, vecs[i].exp_drop});
            if (vecs[i].chk_abcd) check_quad($sformatf("v%0d abcd", i), vecs[i].exp_abcd);
        end

        // ---- held quad with offered samples: drop_err is sticky ----
        drive(0, 1, 3'd1, 0, 0); step_edge();
        drive(0, 1, 3'd2, 0, 0); step_edge();
        drive(0, 1, 3'd3, 0, 0); step_edge();
        drive(0, 1, 3'd4, 0, 0); step_edge();
        held = q4(1,2,3,4);
        check("hold out_valid", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 3'd5, 0, 0);
            check("hold in_ready", {31'd0, in_ready}, 32'd0);
            step_edge();
            check_quad("hold abcd stable", held);
            check("hold drop_err", {31'd0, drop_err}, 32'd1);
        end
        drive(0, 0, 3'd0, 0, 1); step_edge();
        check("drop after handoff ov", {31'd0, out_valid}, 32'd0);
        check("drop after handoff cnt", {24'd0, group_count}, 32'd2);
        check("drop sticky 1", {31'd0, drop_err}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 3'(k), 0, 0); step_edge();
        end
        drive(0, 0, 3'd0, 0, 1); step_edge();
        check("drop sticky 2", {31'd0, drop_err}, 32'd1);
        check("cnt after 2nd quad", {24'd0, group_count}, 32'd3);
        drive(1, 0, 3'd0, 0, 0); step_edge();
        check("drop cleared by rst", {31'd0, drop_err}, 32'd0);
        check("cnt cleared by rst", {24'd0, group_count}, 32'd0);

        // ---- 256 quads, out_ready tied high ----
        beat = 0; seq = 0; quads_seen = 0; exp_cnt = 0; prev_ov = 1'b0; cur = '0;
        budget = 256 * 5 + 50;
        while (quads_seen < 256 && budget > 0) begin
            @(negedge clk);
            rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
            #1;
            if (in_ready) begin
                in_valid = 1'b1;
                in_data  = 3'((seq * 3 + beat) % 8);
                cur[11 - 3*beat -: 3] = in_data;
                beat++;
                if (beat == 4) begin
                    exp_q.push_back(cur);
                    beat = 0;
                    seq++;
                end
            end else begin
                in_valid = 1'b0;
            end
            step_edge();
            budget--;
            if (prev_ov) exp_cnt = (exp_cnt + 1) % 256;
            check("wrap group_count", {24'd0, group_count}, 32'(exp_cnt));
            if (out_valid) begin
                if (prev_ov) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL wrap ov width: got 2+ cycles expected 1 (quad %0d)", quads_seen);
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL wrap unexpected quad: got out_valid expected none");
                end else begin
                    got = exp_q.pop_front();
                    check_quad("wrap abcd", got);
                end
                quads_seen++;
            end
            prev_ov = out_valid;
        end
        if (budget == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL wrap timeout: got %0d quads expected 256", quads_seen);
        end
        drive(0, 0, 3'd0, 0, 1); step_edge();
        check("wrap final count", {24'd0, group_count}, 32'd0);
        check("wrap no drop_err", {31'd0, drop_err}, 32'd0);
        check("wrap out_valid low", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
